// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, ingredient indices and default drink tables for beverage_vend_ctrl
package vend_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CREDIT, S_DISPENSE, S_DONE, S_REFUND} vend_state_t;
  localparam int ING_AGUA = 0;
  localparam int ING_CAFE = 1;
  localparam int ING_LECHE = 2;
  localparam int ING_CHOCO = 3;
  localparam int ING_AZUCAR = 4;
  localparam logic [31:0] DEF_PRICES = {8'd7, 8'd5, 8'd4, 8'd3};
  // one 20-bit row per drink, drink 0 lowest; nibbles azucar..agua from MSB to LSB
  localparam logic [79:0] DEF_ING_SECS = {20'h11111, 20'h01201, 20'h10211, 20'h00021};
endpackage

// File: rtl/beverage_vend_ctrl_if.sv
// beverage_vend_ctrl_if: coin/button inputs and valve/credit/change outputs of the vending controller
interface beverage_vend_ctrl_if #(
  parameter int N_DRINKS = 4,
  parameter int N_INGR = 5,
  parameter int CREDIT_W = 8
);
  logic coin_lo, coin_hi, cancel;
  logic [N_DRINKS-1:0] sel;
  logic [N_INGR-1:0] valve;
  logic busy, drink_ready, change_valid, coin_reject, price_err;
  logic [CREDIT_W-1:0] credit, change;
  modport master (
    output coin_lo, coin_hi, sel, cancel,
    input valve, busy, drink_ready, credit, change, change_valid, coin_reject, price_err
  );
  modport slave (
    input coin_lo, coin_hi, sel, cancel,
    output valve, busy, drink_ready, credit, change, change_valid, coin_reject, price_err
  );
endinterface

// File: rtl/vend_tick_gen.sv
// vend_tick_gen: one-cycle tick every TICK_CYCLES clocks, restartable through clr
module vend_tick_gen #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_CYCLES - 1);
  always_ff @(posedge clk) cnt <= (rst || clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/beverage_vend_ctrl.sv
// beverage_vend_ctrl: coin credit, drink selection and timed valve sequencing; VEND_TIMEOUT_EN adds an idle-credit refund
module beverage_vend_ctrl import vend_pkg::*; #(
  parameter int N_DRINKS = 4,
  parameter int N_INGR = 5,
  parameter int CREDIT_W = 8,
  parameter int MAX_CREDIT = 11,
  parameter int COIN_LO_VAL = 1,
  parameter int COIN_HI_VAL = 5,
  parameter logic [N_DRINKS*CREDIT_W-1:0] PRICES = DEF_PRICES,
  parameter logic [N_DRINKS*N_INGR*4-1:0] ING_SECS = DEF_ING_SECS,
`ifdef VEND_TIMEOUT_EN
  parameter int TIMEOUT_SECS = 30,
`endif
  parameter int TICK_CYCLES = 50_000_000
) (
  input logic clk,
  input logic rst,
  beverage_vend_ctrl_if.slave bus
);
  localparam int DW = N_DRINKS > 1 ? $clog2(N_DRINKS) : 1;
  localparam int IW = $clog2(N_INGR + 1);
  vend_state_t st, nxt;
  logic [DW-1:0] d, dsel, dd;
  logic [IW-1:0] ing, from, nxt_ing;
  logic [3:0] rem, nxt_rem;
  logic [CREDIT_W-1:0] credit_q, change_q, val;
  logic [CREDIT_W:0] sum;
  logic rej_q, perr_q, tick, tmo;
  logic accept, perr, quit, in_coin, coin_any, coin_ok, rej, step_end, disp_done;
  function automatic logic [CREDIT_W-1:0] price_of(input logic [DW-1:0] x);
    return PRICES[int'(x)*CREDIT_W +: CREDIT_W];
  endfunction
  function automatic logic [3:0] secs_of(input logic [DW-1:0] x, input logic [IW-1:0] i);
    return (i < IW'(N_INGR)) ? ING_SECS[(int'(x)*N_INGR + int'(i))*4 +: 4] : 4'd0;
  endfunction
  // first ingredient at or after 'start' with a nonzero duration, N_INGR when none is left
  function automatic logic [IW-1:0] first_nz(input logic [DW-1:0] x, input logic [IW-1:0] start);
    logic [IW-1:0] r;
    r = IW'(N_INGR);
    for (int i = N_INGR - 1; i >= 0; i--)
      if (IW'(i) >= start && secs_of(x, IW'(i)) != 4'd0) r = IW'(i);
    return r;
  endfunction
  vend_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (.clk(clk), .rst(rst), .clr(accept || step_end), .tick(tick));
  always_comb begin
    dsel = '0;
    for (int i = N_DRINKS - 1; i >= 0; i--) if (bus.sel[i]) dsel = DW'(i);
  end
  assign accept = st == S_CREDIT && |bus.sel && credit_q >= price_of(dsel);
  assign perr = st == S_CREDIT && |bus.sel && !accept;
  assign quit = st == S_CREDIT && !(|bus.sel) && (bus.cancel || tmo);
  assign in_coin = st == S_IDLE || st == S_CREDIT;
  assign coin_any = bus.coin_lo || bus.coin_hi;
  assign val = bus.coin_hi ? CREDIT_W'(COIN_HI_VAL) : bus.coin_lo ? CREDIT_W'(COIN_LO_VAL) : '0;
  assign sum = {1'b0, credit_q} + {1'b0, val};
  assign coin_ok = in_coin && coin_any && sum <= (CREDIT_W+1)'(MAX_CREDIT) && !accept && !quit;
  assign rej = (bus.coin_lo && bus.coin_hi) || (coin_any && !coin_ok);
  assign step_end = st == S_DISPENSE && tick && rem == 4'd1;
  assign dd = accept ? dsel : d;
  assign from = accept ? '0 : ing + 1'b1;
  assign nxt_ing = first_nz(dd, from);
  assign nxt_rem = secs_of(dd, nxt_ing);
  assign disp_done = ing == IW'(N_INGR) || (step_end && nxt_ing == IW'(N_INGR));
`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_SECS + 1);
  logic [TW-1:0] tcnt;
  logic act;
  assign act = coin_any || |bus.sel || bus.cancel;
  assign tmo = st == S_CREDIT && tick && !act && tcnt == TW'(TIMEOUT_SECS - 1);
  always_ff @(posedge clk) tcnt <= (rst || st != S_CREDIT || act) ? '0 : tick ? tcnt + 1'b1 : tcnt;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) st <= rst ? S_IDLE : nxt;
  always_comb begin
    nxt = st;
    case (st)
      S_IDLE: nxt = coin_ok ? S_CREDIT : S_IDLE;
      S_CREDIT: nxt = accept ? S_DISPENSE : quit ? S_REFUND : S_CREDIT;
      S_DISPENSE: nxt = disp_done ? S_DONE : S_DISPENSE;
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    bus.busy = st == S_DISPENSE;
    bus.drink_ready = st == S_DONE;
    bus.change_valid = st == S_DONE || st == S_REFUND;
    bus.valve = (st == S_DISPENSE && ing < IW'(N_INGR)) ? N_INGR'(1) << ing : '0;
  end
  assign bus.credit = credit_q;
  assign bus.change = change_q;
  assign bus.coin_reject = rej_q;
  assign bus.price_err = perr_q;
  // change is settled on the way into DONE/REFUND so it is valid alongside change_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= '0;
      change_q <= '0;
      rej_q <= 1'b0;
      perr_q <= 1'b0;
      d <= '0;
      ing <= '0;
      rem <= '0;
    end else begin
      rej_q <= rej;
      perr_q <= perr;
      credit_q <= (nxt == S_DONE || nxt == S_REFUND) ? '0 : coin_ok ? sum[CREDIT_W-1:0] : credit_q;
      change_q <= nxt == S_DONE ? credit_q - price_of(d) : nxt == S_REFUND ? credit_q : change_q;
      if (accept) d <= dsel;
      if (accept || step_end) begin
        ing <= nxt_ing;
        rem <= nxt_rem;
      end else if (st == S_DISPENSE && tick) rem <= rem - 4'd1;
    end
  end
endmodule

// File: tb/tb_beverage_vend_ctrl.sv
// tb_beverage_vend_ctrl: directed checks of credit, selection, dispense timing, refund and reset
module tb_beverage_vend_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  beverage_vend_ctrl_if #(.N_DRINKS(4), .N_INGR(5), .CREDIT_W(8)) bus();
  beverage_vend_ctrl #(
`ifdef VEND_TIMEOUT_EN
    .TIMEOUT_SECS(2),
`endif
    .TICK_CYCLES(4)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic coin(input logic lo, input logic hi);
    bus.coin_lo = lo;
    bus.coin_hi = hi;
    cyc();
    bus.coin_lo = 1'b0;
    bus.coin_hi = 1'b0;
  endtask
  task automatic press(input logic [3:0] s);
    bus.sel = s;
    cyc();
    bus.sel = '0;
  endtask
  task automatic refund;
    bus.cancel = 1'b1;
    cyc();
    bus.cancel = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n;
    logic [4:0] ev;
    bus.coin_lo = 1'b0;
    bus.coin_hi = 1'b0;
    bus.sel = '0;
    bus.cancel = 1'b0;
    cyc(2);
    chk("rst_valve", bus.valve, 0);
    chk("rst_credit", bus.credit, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cv", bus.change_valid, 0);
    rst = 1'b0;
    coin(0, 1);
    coin(1, 0);
    coin(1, 0);
    chk("credit7", bus.credit, 7);
    press(4'b0100);
    chk("d2_busy", bus.busy, 1);
    for (int c = 1; c <= 16; c++) begin
      ev = c <= 4 ? 5'b00001 : c <= 12 ? 5'b00100 : 5'b01000;
      chk("d2_valve", bus.valve, ev);
      cyc();
    end
    chk("d2_ready", bus.drink_ready, 1);
    chk("d2_cv", bus.change_valid, 1);
    chk("d2_change", bus.change, 2);
    chk("d2_credit", bus.credit, 0);
    chk("d2_valve_off", bus.valve, 0);
    cyc();
    chk("d2_ready_end", bus.drink_ready, 0);
    chk("d2_idle", bus.busy, 0);
    chk("d2_change_hold", bus.change, 2);
    coin(0, 1);
    coin(0, 1);
    chk("credit10", bus.credit, 10);
    coin(0, 1);
    chk("over_rej", bus.coin_reject, 1);
    chk("over_credit", bus.credit, 10);
    cyc();
    chk("rej_pulse", bus.coin_reject, 0);
    refund();
    chk("ref10_cv", bus.change_valid, 1);
    chk("ref10_change", bus.change, 10);
    chk("ref10_credit", bus.credit, 0);
    cyc();
    coin(1, 1);
    chk("both_credit", bus.credit, 5);
    chk("both_rej", bus.coin_reject, 1);
    refund();
    chk("ref5_change", bus.change, 5);
    cyc();
    coin(1, 0);
    coin(1, 0);
    coin(1, 0);
    press(4'b1000);
    chk("perr", bus.price_err, 1);
    chk("perr_credit", bus.credit, 3);
    chk("perr_busy", bus.busy, 0);
    cyc();
    chk("perr_pulse", bus.price_err, 0);
    refund();
    chk("ref3_cv", bus.change_valid, 1);
    chk("ref3_change", bus.change, 3);
    cyc();
    chk("ref3_cv_end", bus.change_valid, 0);
    chk("ref3_hold", bus.change, 3);
    repeat (4) coin(1, 0);
    chk("credit4", bus.credit, 4);
    bus.sel = 4'b0011;
    bus.coin_lo = 1'b1;
    cyc();
    bus.sel = '0;
    bus.coin_lo = 1'b0;
    chk("d0_rej", bus.coin_reject, 1);
    chk("d0_busy", bus.busy, 1);
    chk("d0_valve", bus.valve, 5'b00001);
    chk("d0_credit", bus.credit, 4);
    n = 0;
    while (!bus.drink_ready && n < 40) begin
      cyc();
      n++;
    end
    chk("d0_ready", bus.drink_ready, 1);
    chk("d0_len", n, 12);
    chk("d0_change", bus.change, 1);
    cyc();
    press(4'b0001);
    chk("idle_sel_busy", bus.busy, 0);
    chk("idle_sel_perr", bus.price_err, 0);
    coin(0, 1);
    press(4'b0100);
    cyc(5);
    chk("mid_valve", bus.valve, 5'b00100);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_valve", bus.valve, 0);
    chk("mid_rst_credit", bus.credit, 0);
    chk("mid_rst_busy", bus.busy, 0);
    coin(1, 0);
    chk("post_rst_credit", bus.credit, 1);
    refund();
    chk("post_rst_change", bus.change, 1);
    cyc();
`ifdef VEND_TIMEOUT_EN
    coin(0, 1);
    n = 0;
    while (!bus.change_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("tmo_cv", bus.change_valid, 1);
    chk("tmo_change", bus.change, 5);
    chk("tmo_credit", bus.credit, 0);
    cyc();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/beverage_vend_ctrl.md
Name: beverage_vend_ctrl

Overview:
- Parametrised beverage vending controller for the coffee-machine design.
- Accepts coins and takes a one-hot drink selection, checked against a per-drink price table.
- Sequences ingredient valves for a per-drink, per-ingredient number of seconds, then reports change.
- Sits between the coin/button debouncers and the valve drivers; its credit/change outputs feed the existing binary-to-BCD and 7-segment path.

Parameters:
- N_DRINKS, 4, number of selectable drinks.
- N_INGR, 5, number of ingredient valves (0 agua, 1 cafe, 2 leche, 3 choco, 4 azucar).
- CREDIT_W, 8, width of credit/change/price values, in units of 100.
- MAX_CREDIT, 11, maximum accepted credit.
- COIN_LO_VAL, 1, value of low coin (100).
- COIN_HI_VAL, 5, value of high coin (500).
- PRICES, {8'd7,8'd5,8'd4,8'd3}, packed N_DRINKS x CREDIT_W; drink 0 is in the LSBs.
- ING_SECS, packed N_DRINKS x N_INGR x 4 bits: seconds per ingredient, 0 = skip; default table in the package.
- TICK_CYCLES, 50_000_000, clk cycles per 1 s tick.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- coin_lo  in  1  one-cycle pulse: low coin inserted.
- coin_hi  in  1  one-cycle pulse: high coin inserted.
- sel  in  N_DRINKS  drink select pulses; lowest set index wins.
- cancel  in  1  one-cycle pulse: refund request.
- valve  out  N_INGR  ingredient valve enables.
- busy  out  1  high in DISPENSE.
- drink_ready  out  1  one-cycle pulse at end of dispense.
- credit  out  CREDIT_W  current credit.
- change  out  CREDIT_W  change amount; held until the next transaction.
- change_valid  out  1  one-cycle pulse when change is updated.
- coin_reject  out  1  one-cycle pulse: coin refused.
- price_err  out  1  one-cycle pulse: selection refused for insufficient credit.

Behaviour:
- Reset (synchronous, same cycle):
  - state=IDLE.
  - valve, credit, change, all pulse outputs = 0; busy=0; tick counter = 0.
- Tick generator:
  - Free-running, wraps at TICK_CYCLES-1 and emits a one-cycle tick.
  - It is zeroed on entry to DISPENSE and on every ingredient step change, so each step lasts exactly ING_SECS*TICK_CYCLES cycles.
- FSM states: IDLE, CREDIT, DISPENSE, DONE, REFUND.
- IDLE / CREDIT coin handling:
  - A coin adds its value to credit next cycle; IDLE then moves to CREDIT.
  - If credit+value > MAX_CREDIT, credit is unchanged and coin_reject pulses.
  - coin_lo and coin_hi in the same cycle: coin_hi processed, coin_lo rejected.
- CREDIT selection:
  - With sel!=0, drink d = lowest set bit.
  - If credit >= PRICES[d]: latch d and go to DISPENSE; any coin that same cycle is rejected.
  - Else: price_err pulses and the state stays CREDIT.
  - sel while in IDLE is ignored.
- CREDIT cancel: cancel (with no valid sel) goes to REFUND; sel has priority over cancel.
- DISPENSE:
  - busy=1. Steps through ingredient i = 0..N_INGR-1, skipping entries with ING_SECS=0.
  - valve[i]=1 (one-hot) for ING_SECS[d][i] ticks, then advances to the next nonzero i without a gap cycle.
  - After the last step, go to DONE.
  - Coins are rejected and cancel/sel are ignored while dispensing.
  - A drink whose entries are all zero goes straight to DONE after 1 cycle.
- DONE (1 cycle):
  - change = credit - PRICES[d]; credit = 0.
  - drink_ready=1, change_valid=1; then IDLE.
- REFUND (1 cycle):
  - change = credit; credit = 0; change_valid=1; then IDLE.
- Reset mid-DISPENSE: valves close immediately and credit is lost (no refund).
- Arithmetic: unsigned; credit never underflows (guarded by the price check) and never exceeds MAX_CREDIT.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- When defined:
  - Added parameter TIMEOUT_SECS (default 30).
  - In CREDIT, ticks with no coin/sel/cancel are counted; reaching TIMEOUT_SECS goes to REFUND.
  - Any accepted or rejected coin, or any sel/cancel, clears the count.
- When undefined: credit is held indefinitely and no timeout counter is synthesised.

Decomposition:
- Package vend_pkg holds:
  - state enum vend_state_t.
  - default PRICES and ING_SECS tables.
  - ingredient index constants ING_AGUA..ING_AZUCAR.
- Sub-module vend_tick_gen (parameter TICK_CYCLES; inputs clk, rst, clr; output tick).

Test Plan:
- TICK_CYCLES=4. coin_hi, coin_lo, coin_lo -> credit=7. sel=4'b0100 (price 5) -> busy; valves follow ING_SECS[2] durations x4 cycles; DONE: change=2, credit=0, drink_ready=1.
- Credit 10, then coin_hi -> coin_reject=1, credit stays 10.
- Credit 3, sel=4'b1000 (price 7) -> price_err=1, stays CREDIT. Then cancel -> change=3, change_valid=1, IDLE.
- sel=4'b0011 with credit 4 -> drink 0 chosen, change=1. A coin_lo in the same cycle is rejected.
- rst asserted midway through the second ingredient -> next cycle valve=0, credit=0, busy=0, IDLE.
- VEND_TIMEOUT_EN, TIMEOUT_SECS=2. Credit 5 idle for 2 ticks -> REFUND, change=5.
